// File: rtl/run_sequencer.sv
// Multi-run CPU launcher: loads up to NUM_RUNS start addresses, launches them back to back, and records per-run cycle counts.
// Latency: start pulse 1 cycle after go; 2 cycles from done to next start; all_done 1 cycle after last record.
// Backpressure: none; go/load outside IDLE are dropped, a hung run is abandoned after TIMEOUT_CYC. Option macro: RUN_SEQ_HALT_ON_TIMEOUT_EN.
module run_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int NUM_RUNS    = 4,
    parameter int CNT_W       = 15,
    parameter int TIMEOUT_CYC = 20000,
    localparam int IDX_W      = $clog2(NUM_RUNS)
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              go_i,
    input  logic              cpu_done_i,
    output logic              cpu_start_o,
    output logic [ADDR_W-1:0] cpu_start_addr_o,
    output logic              busy_o,
    output logic              all_done_o,
    output logic [IDX_W-1:0]  run_idx_o,
    output logic [IDX_W:0]    loaded_o,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic              rd_timeout_o,
    output logic              rd_valid_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(NUM_RUNS);
    localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W+1)'(1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]          state_q, state_d;
    logic [IDX_W:0]      loaded_q, loaded_d;
    logic [IDX_W-1:0]    run_idx_q, run_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                go_pend_q, go_pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_RUNS-1:0] valid_q, valid_d;

    logic [ADDR_W-1:0]   tab_q     [NUM_RUNS];
    logic [CNT_W-1:0]    res_cnt_q [NUM_RUNS];
    logic                res_to_q  [NUM_RUNS];

    logic                tab_we;
    logic                res_we;
    logic [CNT_W-1:0]    res_cnt_wd;
    logic                res_to_wd;
    logic                halt;

    // Early stop after a timed-out run is a build option; otherwise every loaded run is launched.
`ifdef RUN_SEQ_HALT_ON_TIMEOUT_EN
    assign halt = res_to_q[run_idx_q];
`else
    assign halt = 1'b0;
`endif

    // Next-state logic for the sequencer FSM and its table write strobes.
    always_comb begin
        state_d    = state_q;
        loaded_d   = loaded_q;
        run_idx_d  = run_idx_q;
        cnt_d      = cnt_q;
        go_pend_d  = 1'b0;
        addr_d     = addr_q;
        valid_d    = valid_q;
        tab_we     = 1'b0;
        res_we     = 1'b0;
        res_cnt_wd = '0;
        res_to_wd  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A go arriving with a load is deferred one cycle so it sees the new count.
                if (go_pend_q || (go_i && !load_valid_i)) begin
                    if (loaded_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        valid_d   = '0;
                        run_idx_d = '0;
                        state_d   = S_LAUNCH;
                    end
                end else if (load_valid_i) begin
                    if (loaded_q < FULL_CNT) begin
                        tab_we   = 1'b1;
                        loaded_d = loaded_q + ONE_CNT;
                    end
                    go_pend_d = go_i;
                end
            end
            S_LAUNCH: begin
                addr_d  = tab_q[run_idx_q];
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a timeout landing on the same cycle.
                if (cpu_done_i) begin
                    res_we     = 1'b1;
                    res_cnt_wd = cnt_q + 1'b1;
                    res_to_wd  = 1'b0;
                    state_d    = S_RECORD;
                end else if (cnt_q == TO_LAST) begin
                    res_we     = 1'b1;
                    res_cnt_wd = TO_VAL;
                    res_to_wd  = 1'b1;
                    state_d    = S_RECORD;
                end else if (!(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECORD: begin
                valid_d[run_idx_q] = 1'b1;
                if (halt || ({1'b0, run_idx_q} == (loaded_q - ONE_CNT))) begin
                    state_d = S_FINISH;
                end else begin
                    run_idx_d = run_idx_q + 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset that aborts any run in flight.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            loaded_q  <= '0;
            run_idx_q <= '0;
            cnt_q     <= '0;
            go_pend_q <= 1'b0;
            addr_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            loaded_q  <= loaded_d;
            run_idx_q <= run_idx_d;
            cnt_q     <= cnt_d;
            go_pend_q <= go_pend_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
        end
    end

    // Address table and result tables; entries survive across sequences until reset.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_RUNS; i++) begin
                tab_q[i]     <= '0;
                res_cnt_q[i] <= '0;
                res_to_q[i]  <= 1'b0;
            end
        end else begin
            if (tab_we) begin
                tab_q[loaded_q[IDX_W-1:0]] <= load_addr_i;
            end
            if (res_we) begin
                res_cnt_q[run_idx_q] <= res_cnt_wd;
                res_to_q[run_idx_q]  <= res_to_wd;
            end
        end
    end

    assign cpu_start_o      = (state_q == S_LAUNCH);
    assign cpu_start_addr_o = (state_q == S_LAUNCH) ? tab_q[run_idx_q] : addr_q;
    assign busy_o           = (state_q != S_IDLE);
    assign all_done_o       = (state_q == S_FINISH);
    assign run_idx_o        = run_idx_q;
    assign loaded_o         = loaded_q;
    assign rd_count_o       = res_cnt_q[rd_idx_i];
    assign rd_timeout_o     = res_to_q[rd_idx_i];
    assign rd_valid_o       = valid_q[rd_idx_i];

endmodule
